aes_sram_writer: RTL and testbench
==================================

AES_SRAM_WRITER -- requirements
Module: aes_sram_writer

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 aes_done  in  1  one-cycle pulse from the AES core; data_out valid this cycle.
REQ-005 data_out  in  129  [127:0] processed block, [128] final-block flag.
REQ-006 read_addr  in  1  one-cycle pulse; sram_addr valid this cycle.
REQ-007 sram_addr  in  32  SRAM base byte address for the result stream.
REQ-008 mem_ack  in  1  SRAM accepts the current word when high.
REQ-009 mem_wen  out  1  SRAM write request, held until acknowledged.
REQ-010 mem_addr  out  32  SRAM byte address of the current word.
REQ-011 mem_wdata  out  32  SRAM write data word.
REQ-012 fifo_full  out  1  block buffer full; stall signal back to the AES core.
REQ-013 busy  out  1  high while not IDLE or buffer non-empty.
REQ-014 wr_done  out  1  one-cycle pulse after the final block is fully written.
REQ-015 overflow  out  1  sticky; a block was dropped.

Function
REQ-016 SHALL buffer blocks in a 4-entry, 129-bit FIFO; push on aes_done, pop after the 4th word of the head entry is acknowledged.
REQ-017 Push when full: block dropped, FIFO unchanged, overflow set.
REQ-018 Push and pop in the same cycle while full: both SHALL occur; no overflow.
REQ-019 fifo_full SHALL be combinational from occupancy == 4.
REQ-020 read_addr SHALL load the write pointer from sram_addr and clear overflow only when in IDLE with an empty FIFO; otherwise it is ignored.
REQ-021 FSM states: IDLE, WRITE, DONE.
REQ-022 IDLE -> WRITE when the FIFO is non-empty, with beat counter = 0.
REQ-023 In WRITE, mem_wen=1, mem_addr=pointer, and mem_wdata=head[127-32*beat -: 32] (MSW first).
REQ-024 When mem_ack is sampled high in WRITE: pointer += 4 (mod 2^32, wraps silently) and beat += 1. If beat was 3, the FIFO pops and beat returns to 0.
REQ-025 After the pop in REQ-024: if head[128]=1, go to DONE; else if the FIFO is still non-empty, stay in WRITE; else go to IDLE.
REQ-026 mem_addr and mem_wdata SHALL be stable while mem_wen=1 and mem_ack=0; mem_ack outside WRITE is ignored.
REQ-027 DONE SHALL assert wr_done for exactly one cycle, then go to IDLE; the pointer is retained.
REQ-028 Latency: aes_done sampled at edge N into an empty FIFO in IDLE gives mem_wen=1 after edge N+1.
REQ-029 Throughput: 4 cycles per block with mem_ack tied high.
REQ-030 mem_wen SHALL be 0 in IDLE and DONE.

Reset
REQ-031 rst SHALL return to IDLE and clear the FIFO, beat counter and pointer (to 0) and overflow.
REQ-032 During reset: mem_wen=0, mem_addr=0, mem_wdata=0, fifo_full=0, busy=0, wr_done=0.
REQ-033 rst mid-WRITE SHALL abandon the block; no further mem_wen until new data arrives.

Verification
REQ-034 read_addr with sram_addr=0x00001111, then aes_done with data_out={1'b1,128'h00112233445566778899AABBCCDDEEFF}, mem_ack=1 -> words 0x00112233@0x1111, 0x44556677@0x1115, 0x8899AABB@0x1119, 0xCCDDEEFF@0x111D, then wr_done pulse.
REQ-035 mem_ack held 0 for 5 cycles on beat 0 -> mem_wen/addr/data stable for all 5 cycles; beat 1 starts the cycle after ack.
REQ-036 6 aes_done pulses back-to-back with mem_ack=0 -> fifo_full after 4; 5th and 6th dropped; overflow=1; after releasing mem_ack, exactly 16 words are written.
REQ-037 Pointer base 0xFFFFFFF8, one block -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
REQ-038 rst asserted during beat 2 -> mem_wen=0 next cycle, busy=0, FIFO empty; a new block starts writing at address 0.
REQ-039 read_addr pulse while busy -> pointer unchanged; write stream continues contiguously.

Source files
------------

// File: rtl/aes_sram_writer.sv
// aes_sram_writer
//   Buffers 129-bit result blocks from an AES core in a 4-entry FIFO and
//   streams each block to SRAM as four 32-bit words, most significant word
//   first, at consecutive byte addresses starting from a loadable pointer.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   aes_done   one-cycle pulse, data_out valid
//   data_out   [127:0] block, [128] final-block flag
//   read_addr  one-cycle pulse, sram_addr valid (honoured only when idle/empty)
//   sram_addr  base byte address for the result stream
//   mem_ack    SRAM accepts the current word
//   mem_wen    SRAM write request, held until acknowledged
//   mem_addr   byte address of the current word
//   mem_wdata  current write data word
//   fifo_full  buffer holds 4 blocks
//   busy       not idle or buffer non-empty
//   wr_done    one-cycle pulse after the final block is written
//   overflow   sticky, a block was dropped
module aes_sram_writer (
  input  logic         clk,
  input  logic         rst,
  input  logic         aes_done,
  input  logic [128:0] data_out,
  input  logic         read_addr,
  input  logic [31:0]  sram_addr,
  input  logic         mem_ack,
  output logic         mem_wen,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic         fifo_full,
  output logic         busy,
  output logic         wr_done,
  output logic         overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_e;

  state_e       state_q, state_d;
  logic [128:0] fifo_q [4];
  logic [1:0]   wr_ptr_q, rd_ptr_q;
  logic [2:0]   count_q, count_d;
  logic [1:0]   beat_q;
  logic [31:0]  addr_q;
  logic         ovf_q;

  logic [128:0] head;
  logic         in_write, ack_w, pop, push, drop, load_ptr;
  logic [31:0]  word;

  assign head     = fifo_q[rd_ptr_q];
  assign in_write = (state_q == S_WRITE);
  assign ack_w    = in_write && mem_ack;
  assign pop      = ack_w && (beat_q == 2'd3);
  assign fifo_full = (count_q == 3'd4);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push     = aes_done && (!fifo_full || pop);
  assign drop     = aes_done && fifo_full && !pop;
  assign count_d  = count_q + {2'b00, push} - {2'b00, pop};
  assign load_ptr = read_addr && (state_q == S_IDLE) && (count_q == 3'd0);

  always_comb begin
    word = '0;
    case (beat_q)
      2'd0: word = head[127:96];
      2'd1: word = head[95:64];
      2'd2: word = head[63:32];
      2'd3: word = head[31:0];
      default: word = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != 3'd0) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (pop) begin
          if (head[128])              state_d = S_DONE;
          else if (count_d != 3'd0)   state_d = S_WRITE;
          else                        state_d = S_IDLE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_wen   = in_write;
  assign mem_addr  = addr_q;
  assign mem_wdata = in_write ? word : '0;
  assign busy      = (state_q != S_IDLE) || (count_q != 3'd0);
  assign wr_done   = (state_q == S_DONE);
  assign overflow  = ovf_q;

  // Storage needs no reset: occupancy is cleared and outputs are gated.
  always_ff @(posedge clk) begin
    if (!rst && push) fifo_q[wr_ptr_q] <= data_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      beat_q   <= '0;
      addr_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      if (ack_w) begin
        beat_q <= beat_q + 2'd1;
        addr_q <= addr_q + 32'd4;
      end
      if (load_ptr) addr_q <= sram_addr;
      if (load_ptr)  ovf_q <= 1'b0;
      else if (drop) ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_sram_writer.sv
module tb_aes_sram_writer;

  logic         clk = 1'b0;
  logic         rst;
  logic         aes_done;
  logic [128:0] data_out;
  logic         read_addr;
  logic [31:0]  sram_addr;
  logic         mem_ack;
  logic         mem_wen;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         fifo_full;
  logic         busy;
  logic         wr_done;
  logic         overflow;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  aes_sram_writer dut (
    .clk       (clk),
    .rst       (rst),
    .aes_done  (aes_done),
    .data_out  (data_out),
    .read_addr (read_addr),
    .sram_addr (sram_addr),
    .mem_ack   (mem_ack),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .fifo_full (fifo_full),
    .busy      (busy),
    .wr_done   (wr_done),
    .overflow  (overflow)
  );

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Block k: word j = 0xB000_0000 | k<<8 | j.
  function automatic logic [128:0] mkblk(input int unsigned k, input logic fin);
    logic [31:0] w0, w1, w2, w3;
    w0 = 32'hB000_0000 | (k << 8) | 0;
    w1 = 32'hB000_0000 | (k << 8) | 1;
    w2 = 32'hB000_0000 | (k << 8) | 2;
    w3 = 32'hB000_0000 | (k << 8) | 3;
    return {fin, w0, w1, w2, w3};
  endfunction

  task automatic load_base(input logic [31:0] base);
    read_addr = 1'b1;
    sram_addr = base;
    cyc();
    read_addr = 1'b0;
    sram_addr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    total_cnt++;
    if ({mem_wen, fifo_full, busy, wr_done, overflow} !== 5'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      $display("FAIL reset_outputs: wen=%b full=%b busy=%b done=%b ovf=%b addr=%h data=%h, required all 0",
               mem_wen, fifo_full, busy, wr_done, overflow, mem_addr, mem_wdata);
    end else pass_cnt++;
    rst = 1'b0;
    cyc();
    total_cnt++;
    if (mem_wen !== 1'b0 || busy !== 1'b0) $display("FAIL reset_idle: wen=%b busy=%b, required 0 0", mem_wen, busy);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [31:0] ew [4];
    logic [31:0] ea [4];
    ew[0] = 32'h00112233; ew[1] = 32'h44556677; ew[2] = 32'h8899AABB; ew[3] = 32'hCCDDEEFF;
    ea[0] = 32'h1111;     ea[1] = 32'h1115;     ea[2] = 32'h1119;     ea[3] = 32'h111D;
    load_base(32'h0000_1111);
    aes_done = 1'b1;
    data_out = {1'b1, 128'h00112233445566778899AABBCCDDEEFF};
    mem_ack  = 1'b1;
    cyc();
    aes_done = 1'b0;
    total_cnt++;
    if (mem_wen !== 1'b0 || busy !== 1'b1) $display("FAIL basic_push: wen=%b busy=%b, required 0 1", mem_wen, busy);
    else pass_cnt++;
    cyc();
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (mem_wen !== 1'b1 || mem_addr !== ea[i] || mem_wdata !== ew[i])
        $display("FAIL basic_word%0d: wen=%b addr=%h data=%h, required 1 %h %h", i, mem_wen, mem_addr, mem_wdata, ea[i], ew[i]);
      else pass_cnt++;
      cyc();
    end
    total_cnt++;
    if (wr_done !== 1'b1 || mem_wen !== 1'b0) $display("FAIL basic_done: done=%b wen=%b, required 1 0", wr_done, mem_wen);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (wr_done !== 1'b0 || busy !== 1'b0 || mem_wen !== 1'b0)
      $display("FAIL basic_after: done=%b busy=%b wen=%b, required 0 0 0", wr_done, busy, mem_wen);
    else pass_cnt++;
    mem_ack = 1'b0;
  endtask

  task automatic test_stall();
    load_base(32'h0000_2000);
    mem_ack  = 1'b0;
    aes_done = 1'b1;
    data_out = mkblk(7, 1'b1);
    cyc();
    aes_done = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (mem_wen !== 1'b1 || mem_addr !== 32'h2000 || mem_wdata !== 32'hB000_0700)
        $display("FAIL stall_hold%0d: wen=%b addr=%h data=%h, required 1 00002000 b0000700", i, mem_wen, mem_addr, mem_wdata);
      else pass_cnt++;
      cyc();
    end
    mem_ack = 1'b1;
    cyc();
    total_cnt++;
    if (mem_wen !== 1'b1 || mem_addr !== 32'h2004 || mem_wdata !== 32'hB000_0701)
      $display("FAIL stall_beat1: wen=%b addr=%h data=%h, required 1 00002004 b0000701", mem_wen, mem_addr, mem_wdata);
    else pass_cnt++;
    for (int i = 0; i < 10 && !wr_done; i++) cyc();
    total_cnt++;
    if (wr_done !== 1'b1) $display("FAIL stall_done: done=%b, required 1", wr_done);
    else pass_cnt++;
    cyc();
    mem_ack = 1'b0;
  endtask

  task automatic test_overflow();
    int unsigned n;
    int unsigned c;
    logic        seen_done;
    load_base(32'h0000_3000);
    mem_ack = 1'b0;
    for (int k = 0; k < 6; k++) begin
      aes_done = 1'b1;
      data_out = mkblk(k, k == 3);
      cyc();
      total_cnt++;
      if (fifo_full !== (k >= 3)) $display("FAIL ovf_full%0d: full=%b, required %b", k, fifo_full, (k >= 3));
      else pass_cnt++;
    end
    aes_done = 1'b0;
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: overflow=%b, required 1", overflow);
    else pass_cnt++;
    mem_ack   = 1'b1;
    n         = 0;
    seen_done = 1'b0;
    for (c = 0; c < 40; c++) begin
      if (wr_done) begin
        seen_done = 1'b1;
        break;
      end
      if (mem_wen) begin
        total_cnt++;
        if (mem_addr !== 32'h3000 + 4 * n || mem_wdata !== (32'hB000_0000 | ((n / 4) << 8) | (n % 4)))
          $display("FAIL ovf_word%0d: addr=%h data=%h, required %h %h", n, mem_addr, mem_wdata,
                   32'h3000 + 4 * n, 32'hB000_0000 | ((n / 4) << 8) | (n % 4));
        else pass_cnt++;
        n++;
      end
      cyc();
    end
    total_cnt++;
    if (!seen_done || n != 16 || c != 16)
      $display("FAIL ovf_count: done=%b words=%0d cycles=%0d, required 1 16 16", seen_done, n, c);
    else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL ovf_still: overflow=%b, required 1", overflow);
    else pass_cnt++;
    cyc();
    mem_ack = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] ea [4];
    ea[0] = 32'hFFFF_FFF8; ea[1] = 32'hFFFF_FFFC; ea[2] = 32'h0000_0000; ea[3] = 32'h0000_0004;
    load_base(32'hFFFF_FFF8);
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL wrap_ovf_clear: overflow=%b, required 0", overflow);
    else pass_cnt++;
    aes_done = 1'b1;
    data_out = mkblk(9, 1'b1);
    mem_ack  = 1'b1;
    cyc();
    aes_done = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (mem_wen !== 1'b1 || mem_addr !== ea[i])
        $display("FAIL wrap_addr%0d: wen=%b addr=%h, required 1 %h", i, mem_wen, mem_addr, ea[i]);
      else pass_cnt++;
      cyc();
    end
    total_cnt++;
    if (wr_done !== 1'b1 || mem_addr !== 32'h0000_0008)
      $display("FAIL wrap_done: done=%b addr=%h, required 1 00000008", wr_done, mem_addr);
    else pass_cnt++;
    cyc();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    load_base(32'h0000_5000);
    aes_done = 1'b1;
    data_out = mkblk(5, 1'b1);
    mem_ack  = 1'b1;
    cyc();
    aes_done = 1'b0;
    cyc();
    cyc();
    cyc();
    total_cnt++;
    if (mem_wen !== 1'b1 || mem_addr !== 32'h5008 || mem_wdata !== 32'hB000_0502)
      $display("FAIL rmid_beat2: wen=%b addr=%h data=%h, required 1 00005008 b0000502", mem_wen, mem_addr, mem_wdata);
    else pass_cnt++;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total_cnt++;
    if ({mem_wen, busy, fifo_full, wr_done} !== 4'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      $display("FAIL rmid_reset: wen=%b busy=%b full=%b done=%b addr=%h data=%h, required all 0",
               mem_wen, busy, fifo_full, wr_done, mem_addr, mem_wdata);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total_cnt++;
      if (mem_wen !== 1'b0 || busy !== 1'b0) $display("FAIL rmid_quiet%0d: wen=%b busy=%b, required 0 0", i, mem_wen, busy);
      else pass_cnt++;
    end
    aes_done = 1'b1;
    data_out = mkblk(6, 1'b1);
    cyc();
    aes_done = 1'b0;
    cyc();
    total_cnt++;
    if (mem_wen !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'hB000_0600)
      $display("FAIL rmid_restart: wen=%b addr=%h data=%h, required 1 00000000 b0000600", mem_wen, mem_addr, mem_wdata);
    else pass_cnt++;
    for (int i = 0; i < 10 && !wr_done; i++) cyc();
    total_cnt++;
    if (wr_done !== 1'b1) $display("FAIL rmid_done: done=%b, required 1", wr_done);
    else pass_cnt++;
    cyc();
    mem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    int unsigned n;
    int unsigned c;
    logic        seen_done;
    load_base(32'h0000_6000);
    mem_ack  = 1'b1;
    aes_done = 1'b1;
    data_out = mkblk(1, 1'b0);
    cyc();
    data_out = mkblk(2, 1'b1);
    cyc();
    aes_done  = 1'b0;
    read_addr = 1'b1;
    sram_addr = 32'hDEAD_0000;
    n         = 0;
    seen_done = 1'b0;
    for (c = 0; c < 30; c++) begin
      if (wr_done) begin
        seen_done = 1'b1;
        break;
      end
      if (mem_wen) begin
        total_cnt++;
        if (mem_addr !== 32'h6000 + 4 * n || mem_wdata !== (32'hB000_0000 | ((n / 4 + 1) << 8) | (n % 4)))
          $display("FAIL b2b_word%0d: addr=%h data=%h, required %h %h", n, mem_addr, mem_wdata,
                   32'h6000 + 4 * n, 32'hB000_0000 | ((n / 4 + 1) << 8) | (n % 4));
        else pass_cnt++;
        n++;
      end
      cyc();
      read_addr = 1'b0;
      sram_addr = '0;
    end
    total_cnt++;
    if (!seen_done || n != 8 || c != 8)
      $display("FAIL b2b_count: done=%b words=%0d cycles=%0d, required 1 8 8", seen_done, n, c);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (busy !== 1'b0 || mem_addr !== 32'h6020)
      $display("FAIL b2b_final: busy=%b addr=%h, required 0 00006020", busy, mem_addr);
    else pass_cnt++;
    mem_ack = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    aes_done  = 1'b0;
    data_out  = '0;
    read_addr = 1'b0;
    sram_addr = '0;
    mem_ack   = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
